// File: rtl/vga_sync_to_count.sv
// Regenerates column/row coordinates from incoming VGA syncs and tracks timing lock.
// Optional macro VGA_SYNC_MEASURE_EN exposes the measured line length and frame length.
module vga_sync_to_count #(
  parameter int g_Total_Col   = 800,
  parameter int g_Total_Row   = 525,
  parameter int g_Lock_Frames = 2,
  parameter int g_Count_Width = 12
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst,
  input  logic                     i_HSync,
  input  logic                     i_VSync,
  output logic                     o_HSync,
  output logic                     o_VSync,
  output logic [g_Count_Width-1:0] o_Col_Count,
  output logic [g_Count_Width-1:0] o_Row_Count,
  output logic                     o_Frame_Start,
  output logic                     o_Locked,
  output logic                     o_Lock_Lost,
  output logic [g_Count_Width-1:0] o_Line_Len,
  output logic [g_Count_Width-1:0] o_Frame_Lines
);

  localparam logic [g_Count_Width-1:0] ONE       = g_Count_Width'(1);
  localparam logic [g_Count_Width-1:0] TOTAL_COL = g_Count_Width'(g_Total_Col);
  localparam logic [g_Count_Width-1:0] TOTAL_ROW = g_Count_Width'(g_Total_Row);
  localparam logic [g_Count_Width-1:0] COL_LIMIT = g_Count_Width'(2 * g_Total_Col);
  localparam logic [g_Count_Width-1:0] ROW_LIMIT = g_Count_Width'(2 * g_Total_Row);
  localparam logic [3:0]               LOCK_N    = 4'(g_Lock_Frames);

  typedef enum logic [1:0] {
    UNLOCKED,
    ACQUIRE,
    LOCKED
  } state_t;

  state_t                     state, state_next;
  logic [3:0]                 good, good_next;
  logic                       lost_next;
  logic                       h_armed, v_armed;
  logic                       hfall, vfall;
  logic                       err_flag, skip_line;
  logic                       check_en, line_err, frame_good, watchdog;
  logic [g_Count_Width-1:0]   line_len, frame_lines;

  // An armed flag blocks a false edge from an input that was already low at reset release.
  assign hfall = h_armed & o_HSync & ~i_HSync;
  assign vfall = v_armed & o_VSync & ~i_VSync;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_HSync <= 1'b1;
      o_VSync <= 1'b1;
      h_armed <= 1'b0;
      v_armed <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      o_HSync <= i_HSync;
      o_VSync <= i_VSync;
      h_armed <= h_armed | i_HSync;
      v_armed <= v_armed | i_VSync;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_Col_Count   <= '0;
      o_Row_Count   <= '0;
      o_Frame_Start <= 1'b0;
    end else begin
      o_Frame_Start <= vfall;
      if (vfall) begin
        o_Col_Count <= '0;
        o_Row_Count <= '0;
      end else if (hfall) begin
        o_Col_Count <= '0;
        o_Row_Count <= (o_Row_Count == '1) ? o_Row_Count : o_Row_Count + ONE;
      end else begin
        o_Col_Count <= (o_Col_Count == '1) ? o_Col_Count : o_Col_Count + ONE;
      end
    end
  end

  assign line_len    = o_Col_Count + ONE;
  assign frame_lines = o_Row_Count + ONE;
  assign check_en    = (state != UNLOCKED) && !skip_line;
  assign line_err    = hfall && check_en && (line_len != TOTAL_COL);
  assign frame_good  = (frame_lines == TOTAL_ROW) && !err_flag && !line_err;
  assign watchdog    = (o_Col_Count >= COL_LIMIT) || (o_Row_Count >= ROW_LIMIT);

  always_comb begin
    // NOTE: defaults first keep every path assigned, so no latches are inferred.
    state_next = state;
    good_next  = good;
    lost_next  = 1'b0;
    case (state)
      UNLOCKED: begin
        if (vfall) begin
          state_next = ACQUIRE;
          good_next  = '0;
        end
      end
      ACQUIRE: begin
        if (vfall) begin
          if (frame_good) begin
            good_next = good + 4'd1;
            if (good_next == LOCK_N) state_next = LOCKED;
          end else begin
            good_next = '0;
          end
        end
      end
      LOCKED: begin
        if (vfall && !frame_good) begin
          state_next = UNLOCKED;
          lost_next  = 1'b1;
        end
      end
      default: state_next = UNLOCKED;
    endcase
    if ((state != UNLOCKED) && watchdog) begin
      state_next = UNLOCKED;
      good_next  = '0;
      lost_next  = (state == LOCKED);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state       <= UNLOCKED;
      good        <= '0;
      err_flag    <= 1'b0;
      skip_line   <= 1'b0;
      o_Locked    <= 1'b0;
      o_Lock_Lost <= 1'b0;
    end else begin
      state       <= state_next;
      good        <= good_next;
      o_Locked    <= (state_next == LOCKED);
      o_Lock_Lost <= lost_next;
      if (vfall)         err_flag <= 1'b0;
      else if (line_err) err_flag <= 1'b1;
      // The line in progress when acquisition starts is partial, so its end is not checked.
      if ((state == UNLOCKED) && vfall) skip_line <= 1'b1;
      else if (hfall)                   skip_line <= 1'b0;
    end
  end

`ifdef VGA_SYNC_MEASURE_EN
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_Line_Len    <= '0;
      o_Frame_Lines <= '0;
    end else begin
      if (hfall) o_Line_Len    <= line_len;
      if (vfall) o_Frame_Lines <= frame_lines;
    end
  end
`else
  assign o_Line_Len    = '0;
  assign o_Frame_Lines = '0;
`endif

endmodule

// File: tb/tb_vga_sync_to_count.sv
// Directed bench for vga_sync_to_count on a scaled 24x12 raster (HSync 4 clk, VSync 2 lines).
// Expected measurement outputs follow VGA_SYNC_MEASURE_EN when it is defined for the build.
module tb_vga_sync_to_count;

  localparam int TC = 24;
  localparam int TR = 12;
  localparam int HS = 4;
  localparam int VS = 2;
  localparam int W  = 12;

  logic         i_Clk, i_Rst, i_HSync, i_VSync;
  logic         o_HSync, o_VSync, o_Frame_Start, o_Locked, o_Lock_Lost;
  logic [W-1:0] o_Col_Count, o_Row_Count, o_Line_Len, o_Frame_Lines;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  vga_sync_to_count #(
    .g_Total_Col  (TC),
    .g_Total_Row  (TR),
    .g_Lock_Frames(2),
    .g_Count_Width(W)
  ) dut (
    .i_Clk        (i_Clk),
    .i_Rst        (i_Rst),
    .i_HSync      (i_HSync),
    .i_VSync      (i_VSync),
    .o_HSync      (o_HSync),
    .o_VSync      (o_VSync),
    .o_Col_Count  (o_Col_Count),
    .o_Row_Count  (o_Row_Count),
    .o_Frame_Start(o_Frame_Start),
    .o_Locked     (o_Locked),
    .o_Lock_Lost  (o_Lock_Lost),
    .o_Line_Len   (o_Line_Len),
    .o_Frame_Lines(o_Frame_Lines)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  function automatic logic [31:0] meas(input int v);
`ifdef VGA_SYNC_MEASURE_EN
    return 32'(v);
`else
    return 32'(v - v);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic h, input logic v);
    @(negedge i_Clk);
    i_HSync = h;
    i_VSync = v;
  endtask

  task automatic sample;
    @(posedge i_Clk);
    #1;
  endtask

  task automatic send_pixel(input int x, input int y);
    drive((x < HS) ? 1'b0 : 1'b1, (y < VS) ? 1'b0 : 1'b1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_hsync"},  32'(o_HSync), 1);
    check({tag, "_vsync"},  32'(o_VSync), 1);
    check({tag, "_col"},    32'(o_Col_Count), 0);
    check({tag, "_row"},    32'(o_Row_Count), 0);
    check({tag, "_fstart"}, 32'(o_Frame_Start), 0);
    check({tag, "_locked"}, 32'(o_Locked), 0);
    check({tag, "_lost"},   32'(o_Lock_Lost), 0);
    check({tag, "_linelen"}, 32'(o_Line_Len), 0);
    check({tag, "_flines"}, 32'(o_Frame_Lines), 0);
  endtask

  // One frame; the head pixel carries the VSync falling edge that evaluates the previous frame.
  task automatic send_frame(input int lines, input int short_line, input logic [31:0] exp_locked,
                            input logic [31:0] exp_lost, input logic [31:0] exp_fl);
    for (int y = 0; y < lines; y++) begin
      int len;
      len = (y == short_line) ? TC - 1 : TC;
      for (int x = 0; x < len; x++) begin
        send_pixel(x, y);
        if (x == 0 && y == 0) begin
          sample;
          check("head_col",    32'(o_Col_Count), 0);
          check("head_row",    32'(o_Row_Count), 0);
          check("head_fstart", 32'(o_Frame_Start), 1);
          check("head_locked", 32'(o_Locked), exp_locked);
          check("head_lost",   32'(o_Lock_Lost), exp_lost);
          check("head_flines", 32'(o_Frame_Lines), exp_fl);
        end else if (x == 1 && y == 0) begin
          sample;
          check("p1_col",    32'(o_Col_Count), 1);
          check("p1_hsync",  32'(o_HSync), 0);
          check("p1_vsync",  32'(o_VSync), 0);
          check("p1_fstart", 32'(o_Frame_Start), 0);
          check("p1_lost",   32'(o_Lock_Lost), 0);
        end else if (x == HS + 1 && y == VS + 1) begin
          sample;
          check("mid_col",    32'(o_Col_Count), HS + 1);
          check("mid_row",    32'(o_Row_Count), VS + 1);
          check("mid_hsync",  32'(o_HSync), 1);
          check("mid_vsync",  32'(o_VSync), 1);
          check("mid_locked", 32'(o_Locked), exp_locked);
        end else if (x == 0 && short_line >= 0 && y == short_line + 1) begin
          sample;
          check("short_linelen", 32'(o_Line_Len), meas(TC - 1));
          check("short_locked",  32'(o_Locked), exp_locked);
        end
      end
    end
  endtask

  initial begin
    i_Rst   = 1'b1;
    i_HSync = 1'b1;
    i_VSync = 1'b1;
    repeat (3) @(posedge i_Clk);
    #1;
    check_reset("rst");

    @(negedge i_Clk);
    i_Rst = 1'b0;
    repeat (2) drive(1'b1, 1'b1);
    sample;
    check("idle_col", 32'(o_Col_Count), 3);

    // Acquire and lock on ideal frames: lock shows right after the third VSync fall.
    send_frame(TR, -1, 0, 0, meas(1));
    send_frame(TR, -1, 0, 0, meas(TR));
    send_frame(TR, -1, 1, 0, meas(TR));
    // Short line while locked: lock holds until the frame is evaluated.
    send_frame(TR, 5, 1, 0, meas(TR));
    send_frame(TR, -1, 0, 1, meas(TR));
    // Reacquire with a short frame in the middle resetting the good-frame count.
    send_frame(TR, -1, 0, 0, meas(TR));
    send_frame(TR - 1, -1, 0, 0, meas(TR));
    send_frame(TR, -1, 0, 0, meas(TR - 1));
    send_frame(TR, -1, 0, 0, meas(TR));
    send_frame(TR, -1, 1, 0, meas(TR));

    // Syncs stuck high: watchdog at col 2*TC, then saturation.
    repeat (25) drive(1'b1, 1'b1);
    sample;
    check("wd_col_at_limit", 32'(o_Col_Count), 2 * TC);
    check("wd_locked_before", 32'(o_Locked), 1);
    check("wd_lost_before",   32'(o_Lock_Lost), 0);
    drive(1'b1, 1'b1);
    sample;
    check("wd_locked_after", 32'(o_Locked), 0);
    check("wd_lost_pulse",   32'(o_Lock_Lost), 1);
    drive(1'b1, 1'b1);
    sample;
    check("wd_lost_single", 32'(o_Lock_Lost), 0);
    repeat (4100) drive(1'b1, 1'b1);
    sample;
    check("sat_col",    32'(o_Col_Count), 4095);
    check("sat_row",    32'(o_Row_Count), TR - 1);
    check("sat_locked", 32'(o_Locked), 0);
    check("sat_lost",   32'(o_Lock_Lost), 0);

    send_frame(TR, -1, 0, 0, meas(TR));
    send_frame(TR, -1, 0, 0, meas(TR));
    send_frame(TR, -1, 1, 0, meas(TR));

    // Reset mid-frame while locked, with HSync held low across release.
    send_pixel(0, 0);
    sample;
    check("pre_rst_locked", 32'(o_Locked), 1);
    for (int y = 0; y < 5; y++) begin
      for (int x = (y == 0) ? 1 : 0; x < TC; x++) send_pixel(x, y);
    end
    @(negedge i_Clk);
    i_Rst   = 1'b1;
    i_HSync = 1'b0;
    i_VSync = 1'b1;
    sample;
    check_reset("rst_mid");
    @(negedge i_Clk);
    @(negedge i_Clk);
    i_Rst = 1'b0;
    sample;
    check("rel_col",   32'(o_Col_Count), 1);
    check("rel_row",   32'(o_Row_Count), 0);
    check("rel_hsync", 32'(o_HSync), 0);
    repeat (2) drive(1'b0, 1'b1);
    sample;
    check("low_hold_col", 32'(o_Col_Count), 3);
    repeat (20) drive(1'b1, 1'b1);
    sample;
    check("rise_col", 32'(o_Col_Count), 23);
    check("rise_row", 32'(o_Row_Count), 0);

    send_frame(TR, -1, 0, 0, meas(1));
    send_frame(TR, -1, 0, 0, meas(TR));
    send_frame(TR, -1, 1, 0, meas(TR));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vga_sync_to_count.md
Name: vga_sync_to_count

Overview:
Receive-side counterpart of the VGA pulse generator. It takes incoming HSync/VSync, regenerates column and row counters aligned to the sync edges, and checks line and frame lengths against the expected timing. It declares lock after N consecutive good frames and reports loss of lock. It sits on the 25 MHz pixel clock ahead of any pattern checker or overlay logic that needs pixel coordinates.

Parameters:
g_Total_Col, 800, expected clocks per line (HSync falling edge to HSync falling edge)
g_Total_Row, 525, expected lines per frame (VSync falling edge to VSync falling edge)
g_Lock_Frames, 2, consecutive good frames required to assert lock (1..15)
g_Count_Width, 12, width of column and row counters; must hold 2*g_Total_Col and 2*g_Total_Row

Ports:
i_Clk  in  1  pixel clock; single clock domain
i_Rst  in  1  synchronous reset, active-high
i_HSync  in  1  horizontal sync, active-low pulse, synchronous to i_Clk
i_VSync  in  1  vertical sync, active-low pulse, synchronous to i_Clk
o_HSync  out  1  i_HSync delayed 1 clock, aligned with counts
o_VSync  out  1  i_VSync delayed 1 clock, aligned with counts
o_Col_Count  out  g_Count_Width  column index since last HSync/VSync falling edge
o_Row_Count  out  g_Count_Width  line index since last VSync falling edge
o_Frame_Start  out  1  1-clock pulse, coincident with counts = 0,0 after a VSync falling edge
o_Locked  out  1  timing lock status
o_Lock_Lost  out  1  1-clock pulse on LOCKED -> UNLOCKED
o_Line_Len  out  g_Count_Width  last measured line length (feature-dependent)
o_Frame_Lines  out  g_Count_Width  last measured frame length (feature-dependent)

Behaviour:
- Reset: o_HSync=1, o_VSync=1, internal sync history=1, counts=0, o_Frame_Start=0, o_Locked=0, o_Lock_Lost=0, o_Line_Len=0, o_Frame_Lines=0, FSM=UNLOCKED, good-frame count=0, frame-error flag=0.
- Edges: hfall = history(1) & i_HSync(0); vfall likewise. An input held low through reset produces no edge until it rises and falls again.
- Counters update on the clock after the edge, so a count of 0 lines up with o_HSync/o_VSync first showing low.
  - vfall (with or without hfall): col<=0, row<=0, o_Frame_Start<=1.
  - hfall only: col<=0, row<=row+1.
  - No edge: col<=col+1.
  - Both counters saturate at all-ones and never wrap.
- Line check: on every hfall, including one coincident with vfall, line_len = col+1.
  - If line_len != g_Total_Col, set the frame-error flag.
  - The first hfall after leaving UNLOCKED is not checked.
- Frame check: on vfall, frame_lines = row+1.
  - The frame is good iff frame_lines == g_Total_Row and the frame-error flag is clear, counting the same-cycle line check.
  - The flag is then cleared.
- FSM states:
  - UNLOCKED: on vfall go to ACQUIRE with good=0; the partial frame is not evaluated.
  - ACQUIRE:
    - On a good frame, good=good+1; if the new value equals g_Lock_Frames, go to LOCKED and set o_Locked=1 on the next clock.
    - On a bad frame, good=0 and stay in ACQUIRE.
  - LOCKED:
    - A bad frame sends the FSM to UNLOCKED: o_Locked=0 and o_Lock_Lost pulses for 1 clock.
    - The line error itself does not drop lock until the frame evaluation at vfall.
  - Watchdog, any state except UNLOCKED: col >= 2*g_Total_Col or row >= 2*g_Total_Row sends the FSM to UNLOCKED and clears good.
    - o_Lock_Lost pulses only if the FSM was in LOCKED.
    - The counters keep saturating.
- Reset asserted mid-frame returns everything to reset values on the next clock edge. Lock must be re-acquired from UNLOCKED.

Optional Feature:
VGA_SYNC_MEASURE_EN:
- Defined: o_Line_Len is loaded with line_len on every hfall, and o_Frame_Lines with frame_lines on every vfall, whether or not the value matches. Both hold between updates.
- Undefined: both outputs are tied to 0. The ports remain present, and lock behaviour is identical.

Test Plan:
- Ideal 800x525 syncs (HSync low 96 clk, VSync low 2 lines), g_Lock_Frames=2 -> o_Locked rises 1 clock after the 3rd VSync falling edge; o_Frame_Start pulses once per frame; col runs 0..799 and row 0..524; o_HSync/o_VSync are i_* delayed by 1.
- After lock, one line shortened to 799 clocks -> o_Locked stays high until the next vfall, then drops with a single o_Lock_Lost pulse; with the macro, o_Line_Len=799 after that line.
- Frame of 524 lines during ACQUIRE -> good resets to 0; lock needs 2 further good frames.
- HSync and VSync stuck high after lock -> once col reaches 1600: o_Locked=0, one o_Lock_Lost pulse, col saturates at 4095.
- i_Rst pulsed mid-frame while locked -> next clock: all outputs at reset values; relock after 3 vfalls.
- i_HSync held low across reset release, then a normal stream -> no count reset until the first genuine falling edge.
